// File: rtl/serialstream_pkg.sv
// rtl/serialstream_pkg.sv - shared frame lengths, stall slots and reset codes for serialstream_pld
package serialstream_pkg;

    localparam int CFG_TX_LEN  = 10;
    localparam int CFG_RX_BITS = 16;
    localparam int RUN_RX_LEN  = 17;
    localparam int RUN_TX_LEN  = 51;

    localparam logic [3:0] CFG_TX_LAST  = 4'(CFG_TX_LEN - 1);
    localparam logic [4:0] CFG_RX_DONE  = 5'(CFG_RX_BITS);
    localparam logic [4:0] CFG_RX_LAST  = 5'(CFG_RX_BITS - 1);
    localparam logic [4:0] RUN_RX_LAST  = 5'(RUN_RX_LEN - 1);
    localparam logic [5:0] RUN_TX_LAST  = 6'(RUN_TX_LEN - 1);
    localparam logic [5:0] STALL_SLOT_A = 6'd17;
    localparam logic [5:0] STALL_SLOT_B = 6'd18;

    localparam logic [7:0] DAC_RESET_CODE = 8'h80;
    localparam logic [2:0] PWR_RESET_CODE = 3'b000;

    typedef logic [5:0] tx_slot_t;
    typedef logic [4:0] rx_slot_t;
    typedef logic [3:0] cfg_slot_t;

    typedef enum logic {
        MODE_CFG = 1'b0,
        MODE_RUN = 1'b1
    } mode_e;

endpackage

// File: rtl/serialstream_pld_tx.sv
// rtl/serialstream_pld_tx.sv - run-phase 51-slot transmit frame generator
//
// clk_i       : stream clock
// rst_i       : synchronous active-high reset
// run_i       : 1 while the stream is in run phase; counter only advances then
// start_i     : first run edge; the frame starts at slot 0 on this edge
// adcsel_i    : ADC mux select, held at slot 0
// adc_ready_i : conversion ready; stalls the frame at slots 17/18 while low
// adc_a_i/b_i : conversion results, held when leaving slot 18
// pgood_i     : power good, sent live in the last slot
// bit_o       : value for the current slot (registered by the top)
module serialstream_pld_tx
    import serialstream_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic        start_i,
    input  logic [2:0]  adcsel_i,
    input  logic        adc_ready_i,
    input  logic [11:0] adc_a_i,
    input  logic [11:0] adc_b_i,
    input  logic        pgood_i,
    output logic        bit_o
);

    tx_slot_t    slot_q, slot_d, cur_slot;
    logic [2:0]  sel_q, sel_d;
    logic [11:0] a_q, a_d, b_q, b_d;
    logic [4:0]  data_off;
    logic [3:0]  bit_idx;
    logic        stall_slot;

    always_comb begin
        cur_slot   = start_i ? '0 : slot_q;
        slot_d     = slot_q;
        sel_d      = sel_q;
        a_d        = a_q;
        b_d        = b_q;
        bit_o      = 1'b0;
        stall_slot = (cur_slot == STALL_SLOT_A) || (cur_slot == STALL_SLOT_B);
        // Data field interleaves B (odd slots) and A (even slots) from slot 21.
        data_off   = 5'(cur_slot - 6'd21);
        bit_idx    = 4'd11 - data_off[4:1];

        if (cur_slot == 6'd0) begin
            bit_o = 1'b0;
        end else if (cur_slot <= 6'd2) begin
            bit_o = sel_q[2];
        end else if (cur_slot <= 6'd4) begin
            bit_o = sel_q[1];
        end else if (cur_slot <= 6'd6) begin
            bit_o = sel_q[0];
        end else if (stall_slot) begin
            bit_o = adc_ready_i;
        end else if ((cur_slot >= 6'd21) && (cur_slot <= 6'd44)) begin
            bit_o = data_off[0] ? a_q[bit_idx] : b_q[bit_idx];
        end else if (cur_slot == RUN_TX_LAST) begin
            bit_o = pgood_i;
        end

        if (run_i) begin
            if (cur_slot == 6'd0) begin
                sel_d = adcsel_i;
            end
            if ((cur_slot == STALL_SLOT_B) && adc_ready_i) begin
                a_d = adc_a_i;
                b_d = adc_b_i;
            end
            if (stall_slot && !adc_ready_i) begin
                slot_d = cur_slot;
            end else if (cur_slot == RUN_TX_LAST) begin
                slot_d = '0;
            end else begin
                slot_d = cur_slot + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= '0;
            sel_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            slot_q <= slot_d;
            sel_q  <= sel_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

endmodule

// File: rtl/serialstream_pld.sv
// rtl/serialstream_pld.sv - serial stream PLD: config/run receive, config transmit, run tx via sub-module
//
// PLDCLK/SYSRST     : stream clock, synchronous active-high reset
// PLDRESETn         : 0 = config phase, 1 = run phase
// PLDI / PLDO       : serial in from / registered serial out to the FPGA
// ZCTL..IMEMSIZE    : static config word, CFG_VALID once all 16 bits latched
// PWR_nSHDN         : active-low shutdown controls
// DAC_DINA/B/C      : DAC codes, DAC_LOAD one-cycle strobes [2]=C [1]=B [0]=A
// ADCSEL_IN, ADC_*  : ADC status and results reported in the run tx frame
// PGOOD_IN          : power good reported in both tx frames
module serialstream_pld
    import serialstream_pkg::*;
#(
    parameter logic [3:0] MAN_ID_VAL = 4'h4,
    parameter logic [3:0] PLD_ID_VAL = 4'h1
) (
    input  logic        PLDCLK,
    input  logic        SYSRST,
    input  logic        PLDRESETn,
    input  logic        PLDI,
    output logic        PLDO,
    output logic [3:0]  ZCTL,
    output logic [5:0]  CLKSEL,
    output logic [2:0]  DMEMSIZE,
    output logic [2:0]  IMEMSIZE,
    output logic        CFG_VALID,
    output logic [2:0]  PWR_nSHDN,
    output logic [7:0]  DAC_DINA,
    output logic [7:0]  DAC_DINB,
    output logic [7:0]  DAC_DINC,
    output logic [2:0]  DAC_LOAD,
    input  logic [2:0]  ADCSEL_IN,
    input  logic        ADC_READY,
    input  logic [11:0] ADC_DATAA,
    input  logic [11:0] ADC_DATAB,
    input  logic        PGOOD_IN
);

    mode_e      mode_q, mode_d;
    logic       enter_cfg, enter_run;

    logic [4:0]  cfg_cnt_q, cfg_cnt_d, cfg_cnt_cur;
    logic [14:0] cfg_sh_q, cfg_sh_d;
    logic [15:0] cfg_word_q, cfg_word_d;
    logic        cfg_valid_q, cfg_valid_d;
    cfg_slot_t   cfg_slot_q, cfg_slot_d, cfg_slot_cur;
    logic [9:0]  cfg_frame;

    rx_slot_t    rx_slot_q, rx_slot_d, rx_cur;
    logic [2:0]  rx_seln_q, rx_seln_d;
    logic [7:0]  rx_code_q, rx_code_d;
    logic [2:0]  rx_pwr_q, rx_pwr_d;

    logic [2:0]  pwr_q, pwr_d;
    logic [7:0]  dina_q, dina_d, dinb_q, dinb_d, dinc_q, dinc_d;
    logic [2:0]  load_q, load_d;
    logic        pldo_q, pldo_d;
    logic        run_bit;

    serialstream_pld_tx u_tx (
        .clk_i       (PLDCLK),
        .rst_i       (SYSRST),
        .run_i       (PLDRESETn),
        .start_i     (enter_run),
        .adcsel_i    (ADCSEL_IN),
        .adc_ready_i (ADC_READY),
        .adc_a_i     (ADC_DATAA),
        .adc_b_i     (ADC_DATAB),
        .pgood_i     (PGOOD_IN),
        .bit_o       (run_bit)
    );

    always_comb begin
        mode_d    = PLDRESETn ? MODE_RUN : MODE_CFG;
        // A mode change is processed on the same edge as slot 0 / bit 1 of the new phase.
        enter_cfg = !PLDRESETn && (mode_q == MODE_RUN);
        enter_run = PLDRESETn && (mode_q == MODE_CFG);

        cfg_cnt_cur  = enter_cfg ? '0 : cfg_cnt_q;
        cfg_slot_cur = enter_cfg ? '0 : cfg_slot_q;
        rx_cur       = enter_run ? '0 : rx_slot_q;
        cfg_frame    = {1'b0, MAN_ID_VAL, PLD_ID_VAL, PGOOD_IN};

        cfg_cnt_d   = cfg_cnt_q;
        cfg_sh_d    = cfg_sh_q;
        cfg_word_d  = cfg_word_q;
        cfg_valid_d = cfg_valid_q;
        cfg_slot_d  = cfg_slot_q;
        rx_slot_d   = rx_slot_q;
        rx_seln_d   = rx_seln_q;
        rx_code_d   = rx_code_q;
        rx_pwr_d    = rx_pwr_q;
        pwr_d       = pwr_q;
        dina_d      = dina_q;
        dinb_d      = dinb_q;
        dinc_d      = dinc_q;
        load_d      = 3'b000;
        pldo_d      = pldo_q;

        if (!PLDRESETn) begin
            if (enter_cfg) begin
                cfg_valid_d = 1'b0;
            end
            cfg_cnt_d = cfg_cnt_cur;
            if (cfg_cnt_cur != CFG_RX_DONE) begin
                cfg_sh_d  = {cfg_sh_q[13:0], PLDI};
                cfg_cnt_d = cfg_cnt_cur + 5'd1;
                if (cfg_cnt_cur == CFG_RX_LAST) begin
                    cfg_word_d  = {cfg_sh_q, PLDI};
                    cfg_valid_d = 1'b1;
                end
            end
            pldo_d     = cfg_frame[CFG_TX_LAST - cfg_slot_cur];
            cfg_slot_d = (cfg_slot_cur == CFG_TX_LAST) ? '0 : cfg_slot_cur + 4'd1;
        end else begin
            pldo_d = run_bit;
            if (rx_cur == 5'd0) begin
                rx_seln_d[2] = PLDI;
            end else if (rx_cur == 5'd1) begin
                rx_seln_d[1] = PLDI;
            end else if (rx_cur == 5'd2) begin
                rx_seln_d[0] = PLDI;
            end else if ((rx_cur >= 5'd4) && (rx_cur <= 5'd11)) begin
                rx_code_d = {rx_code_q[6:0], PLDI};
            end else if ((rx_cur >= 5'd12) && (rx_cur <= 5'd14)) begin
                rx_pwr_d = {rx_pwr_q[1:0], PLDI};
            end else if (rx_cur == RUN_RX_LAST) begin
                pwr_d = rx_pwr_q;
                if (!rx_seln_q[0]) begin
                    dina_d    = rx_code_q;
                    load_d[0] = 1'b1;
                end
                if (!rx_seln_q[1]) begin
                    dinb_d    = rx_code_q;
                    load_d[1] = 1'b1;
                end
                if (!rx_seln_q[2]) begin
                    dinc_d    = rx_code_q;
                    load_d[2] = 1'b1;
                end
            end
            rx_slot_d = (rx_cur == RUN_RX_LAST) ? '0 : rx_cur + 5'd1;
        end
    end

    always_ff @(posedge PLDCLK) begin
        if (SYSRST) begin
            mode_q      <= MODE_CFG;
            cfg_cnt_q   <= '0;
            cfg_sh_q    <= '0;
            cfg_word_q  <= '0;
            cfg_valid_q <= 1'b0;
            cfg_slot_q  <= '0;
            rx_slot_q   <= '0;
            rx_seln_q   <= '0;
            rx_code_q   <= '0;
            rx_pwr_q    <= '0;
            pwr_q       <= PWR_RESET_CODE;
            dina_q      <= DAC_RESET_CODE;
            dinb_q      <= DAC_RESET_CODE;
            dinc_q      <= DAC_RESET_CODE;
            load_q      <= 3'b000;
            pldo_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            cfg_cnt_q   <= cfg_cnt_d;
            cfg_sh_q    <= cfg_sh_d;
            cfg_word_q  <= cfg_word_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_slot_q  <= cfg_slot_d;
            rx_slot_q   <= rx_slot_d;
            rx_seln_q   <= rx_seln_d;
            rx_code_q   <= rx_code_d;
            rx_pwr_q    <= rx_pwr_d;
            pwr_q       <= pwr_d;
            dina_q      <= dina_d;
            dinb_q      <= dinb_d;
            dinc_q      <= dinc_d;
            load_q      <= load_d;
            pldo_q      <= pldo_d;
        end
    end

    assign PLDO      = pldo_q;
    assign ZCTL      = cfg_word_q[15:12];
    assign CLKSEL    = cfg_word_q[11:6];
    assign DMEMSIZE  = cfg_word_q[5:3];
    assign IMEMSIZE  = cfg_word_q[2:0];
    assign CFG_VALID = cfg_valid_q;
    assign PWR_nSHDN = pwr_q;
    assign DAC_DINA  = dina_q;
    assign DAC_DINB  = dinb_q;
    assign DAC_DINC  = dinc_q;
    assign DAC_LOAD  = load_q;

endmodule

// File: tb/tb_serialstream_pld.sv
// tb/tb_serialstream_pld.sv - self-checking bench for serialstream_pld
module tb_serialstream_pld;

    localparam logic [3:0] MAN = 4'h4;
    localparam logic [3:0] PLD = 4'h1;

    logic        PLDCLK = 1'b0;
    logic        SYSRST, PLDRESETn, PLDI, PLDO;
    logic [3:0]  ZCTL;
    logic [5:0]  CLKSEL;
    logic [2:0]  DMEMSIZE, IMEMSIZE;
    logic        CFG_VALID;
    logic [2:0]  PWR_nSHDN;
    logic [7:0]  DAC_DINA, DAC_DINB, DAC_DINC;
    logic [2:0]  DAC_LOAD;
    logic [2:0]  ADCSEL_IN;
    logic        ADC_READY;
    logic [11:0] ADC_DATAA, ADC_DATAB;
    logic        PGOOD_IN;

    serialstream_pld #(.MAN_ID_VAL(MAN), .PLD_ID_VAL(PLD)) dut (
        .PLDCLK(PLDCLK), .SYSRST(SYSRST), .PLDRESETn(PLDRESETn), .PLDI(PLDI), .PLDO(PLDO),
        .ZCTL(ZCTL), .CLKSEL(CLKSEL), .DMEMSIZE(DMEMSIZE), .IMEMSIZE(IMEMSIZE),
        .CFG_VALID(CFG_VALID), .PWR_nSHDN(PWR_nSHDN),
        .DAC_DINA(DAC_DINA), .DAC_DINB(DAC_DINB), .DAC_DINC(DAC_DINC), .DAC_LOAD(DAC_LOAD),
        .ADCSEL_IN(ADCSEL_IN), .ADC_READY(ADC_READY), .ADC_DATAA(ADC_DATAA),
        .ADC_DATAB(ADC_DATAB), .PGOOD_IN(PGOOD_IN)
    );

    always #5 PLDCLK = ~PLDCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          cfg_k;
    logic [15:0] m_asm, m_cfg;
    logic        m_valid;
    logic [7:0]  m_dina, m_dinb, m_dinc;
    logic [2:0]  m_pwr, m_load;
    int          tx_s, rx_s, frame_no;
    logic [2:0]  h_sel;
    logic [11:0] h_a, h_b;
    logic [2:0]  cur_seln, cur_pwr;
    logic [7:0]  cur_code;
    logic [16:0] rx_bits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PLDCLK);
        #1;
    endtask

    task automatic model_reset();
        cfg_k = 0; m_asm = '0; m_cfg = '0; m_valid = 1'b0;
        m_dina = 8'h80; m_dinb = 8'h80; m_dinc = 8'h80; m_pwr = 3'b000; m_load = 3'b000;
        tx_s = 0; rx_s = 0; h_sel = '0; h_a = '0; h_b = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pldo"}, PLDO, 0);
        check({tag, "_cfg"}, {ZCTL, CLKSEL, DMEMSIZE, IMEMSIZE}, 0);
        check({tag, "_cfg_valid"}, CFG_VALID, 0);
        check({tag, "_pwr"}, PWR_nSHDN, 0);
        check({tag, "_dina"}, DAC_DINA, 8'h80);
        check({tag, "_dinb"}, DAC_DINB, 8'h80);
        check({tag, "_dinc"}, DAC_DINC, 8'h80);
        check({tag, "_load"}, DAC_LOAD, 0);
    endtask

    task automatic cfg_cycle(input logic din);
        logic [9:0] fr;
        logic       exp;
        PLDRESETn = 1'b0;
        PLDI      = din;
        PGOOD_IN  = 1'($urandom);
        fr  = {1'b0, MAN, PLD, PGOOD_IN};
        exp = fr[9 - (cfg_k % 10)];
        if (cfg_k < 16) begin
            m_asm = {m_asm[14:0], din};
            if (cfg_k == 15) begin
                m_cfg   = m_asm;
                m_valid = 1'b1;
            end
        end
        step();
        check("cfg_pldo", PLDO, exp);
        check("cfg_valid", CFG_VALID, m_valid);
        check("cfg_fields", {ZCTL, CLKSEL, DMEMSIZE, IMEMSIZE}, m_cfg);
        check("cfg_load", DAC_LOAD, 0);
        cfg_k++;
    endtask

    task automatic run_cycle(input logic ready, input bit rand_data);
        logic [50:0] tf;
        logic [23:0] il;
        logic        exp;
        PLDRESETn = 1'b1;
        ADC_READY = ready;
        PGOOD_IN  = 1'($urandom);
        ADCSEL_IN = 3'($urandom);
        if (rand_data) begin
            ADC_DATAA = 12'($urandom);
            ADC_DATAB = 12'($urandom);
        end
        if (rx_s == 0) begin
            case (frame_no)
                0: begin cur_seln = 3'b010; cur_code = 8'h3C; cur_pwr = 3'b101; end
                1: begin cur_seln = 3'b111; cur_code = 8'($urandom); cur_pwr = 3'($urandom); end
                default: begin cur_seln = 3'($urandom); cur_code = 8'($urandom); cur_pwr = 3'($urandom); end
            endcase
            frame_no++;
            rx_bits = {cur_seln, 1'($urandom), cur_code, cur_pwr, 2'($urandom)};
        end
        PLDI   = rx_bits[16 - rx_s];
        m_load = 3'b000;
        if (rx_s == 16) begin
            m_pwr = cur_pwr;
            if (!cur_seln[0]) begin m_dina = cur_code; m_load[0] = 1'b1; end
            if (!cur_seln[1]) begin m_dinb = cur_code; m_load[1] = 1'b1; end
            if (!cur_seln[2]) begin m_dinc = cur_code; m_load[2] = 1'b1; end
        end
        rx_s = (rx_s == 16) ? 0 : rx_s + 1;

        for (int i = 0; i < 12; i++) begin
            il[23 - 2*i] = h_b[11 - i];
            il[22 - 2*i] = h_a[11 - i];
        end
        tf  = {1'b0, {2{h_sel[2]}}, {2{h_sel[1]}}, {2{h_sel[0]}}, 10'b0,
               {2{ready}}, 2'b0, il, 5'b0, PGOOD_IN};
        exp = tf[50 - tx_s];
        if (tx_s == 0) h_sel = ADCSEL_IN;
        if (tx_s == 18 && ready) begin h_a = ADC_DATAA; h_b = ADC_DATAB; end
        if (!((tx_s == 17 || tx_s == 18) && !ready)) tx_s = (tx_s == 50) ? 0 : tx_s + 1;

        step();
        check("run_pldo", PLDO, exp);
        check("run_dina", DAC_DINA, m_dina);
        check("run_dinb", DAC_DINB, m_dinb);
        check("run_dinc", DAC_DINC, m_dinc);
        check("run_load", DAC_LOAD, m_load);
        check("run_pwr", PWR_nSHDN, m_pwr);
    endtask

    initial begin
        logic [15:0] word;
        SYSRST = 1'b1; PLDRESETn = 1'b0; PLDI = 1'b0; ADCSEL_IN = '0; ADC_READY = 1'b0;
        ADC_DATAA = '0; ADC_DATAB = '0; PGOOD_IN = 1'b0;
        frame_no = 0;
        model_reset();
        repeat (3) step();
        check_reset_state("reset");

        // config phase straight out of reset, directed word then ignored extra bits
        SYSRST = 1'b0;
        word = 16'hA5C3;
        for (int i = 15; i >= 0; i--) cfg_cycle(word[i]);
        check("cfg_zctl", ZCTL, 4'hA);
        check("cfg_clksel", CLKSEL, 6'h17);
        check("cfg_dmem", DMEMSIZE, 3'h0);
        check("cfg_imem", IMEMSIZE, 3'h3);
        check("cfg_valid_set", CFG_VALID, 1);
        for (int i = 0; i < 14; i++) cfg_cycle(1'($urandom));

        // run phase: first rx frame is the directed DAC load
        tx_s = 0; rx_s = 0;
        for (int i = 0; i < 17; i++) run_cycle(1'b1, 1'b1);
        check("rx_dinc", DAC_DINC, 8'h3C);
        check("rx_dina", DAC_DINA, 8'h3C);
        check("rx_dinb", DAC_DINB, 8'h80);
        check("rx_load", DAC_LOAD, 3'b101);
        check("rx_pwr", PWR_nSHDN, 3'b101);
        run_cycle(1'b1, 1'b1);
        check("rx_load_one_cycle", DAC_LOAD, 0);

        // directed stall at slot 17 with known data
        for (int g = 0; g < 60 && tx_s != 17; g++) run_cycle(1'b1, 1'b1);
        ADC_DATAB = 12'h800;
        ADC_DATAA = 12'h001;
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b0, 1'b0);
            check("stall_pldo_low", PLDO, 0);
        end
        run_cycle(1'b1, 1'b0);
        check("stall_release_pldo", PLDO, 1);
        run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) run_cycle(1'b1, 1'b1);

        // randomized run traffic with random stalls
        for (int i = 0; i < 300; i++) run_cycle(1'($urandom_range(0, 3) != 0), 1'b1);

        // mode switch at tx slot 30
        for (int g = 0; g < 60 && tx_s != 30; g++) run_cycle(1'b1, 1'b1);
        cfg_k = 0; m_valid = 1'b0;
        word = 16'($urandom);
        cfg_cycle(word[15]);
        check("modesw_pldo", PLDO, 0);
        check("modesw_cfg_valid", CFG_VALID, 0);
        for (int i = 14; i >= 0; i--) cfg_cycle(word[i]);
        for (int i = 0; i < 12; i++) cfg_cycle(1'($urandom));

        // back to run, then reset during a stall
        tx_s = 0; rx_s = 0;
        for (int g = 0; g < 60 && tx_s != 17; g++) run_cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);
        SYSRST = 1'b1;
        step();
        check_reset_state("stall_reset");
        SYSRST = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
